// File: rtl/axi_writer_pkg.sv
// ============================================================================
// Module : axi_writer_pkg
// Shared state encoding and AXI constants for the burst writer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package axi_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_AW   = 3'd2,
    ST_W    = 3'd3,
    ST_B    = 3'd4
  } wr_state_e;

  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam int         BYTES_PER_BEAT    = 8;
  localparam int         BOUNDARY_4K_BEATS = 512;

endpackage

`default_nettype wire

// File: rtl/axi_burst_len_calc.sv
// ============================================================================
// Module : axi_burst_len_calc
// Burst length = min(remaining, MAX_BURST, beats left before the 4 KB line).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module axi_burst_len_calc
  import axi_writer_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic [31:0] remaining_i,
  input  logic [8:0]  beat_offset_i,
  output logic [8:0]  burst_o
);

  logic [9:0] w_to_4k;
  logic [8:0] w_rem_clamped;

  // beat_offset_i is addr[11:3], so w_to_4k ranges 1..512.
  assign w_to_4k       = 10'(BOUNDARY_4K_BEATS) - {1'b0, beat_offset_i};
  assign w_rem_clamped = (remaining_i > 32'(MAX_BURST)) ? 9'(MAX_BURST) : remaining_i[8:0];
  assign burst_o       = ({1'b0, w_rem_clamped} > w_to_4k) ? w_to_4k[8:0] : w_rem_clamped;

endmodule

`default_nettype wire

// File: rtl/axi_mm_burst_writer.sv
// ============================================================================
// Module : axi_mm_burst_writer
// AXI4 write master: streams 64-bit beats into INCR bursts, one outstanding.
// Option : AXI_MM_BURST_WRITER_ABORT_EN - stop transfer on non-OKAY bresp.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module axi_mm_burst_writer
  import axi_writer_pkg::*;
#(
  parameter int AXI_IDWIDTH = 4,
  parameter int AXI_AWIDTH  = 64,
  parameter int AXI_DWIDTH  = 64,
  parameter int MAX_BURST   = 16,
  parameter int AXI_ID      = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [AXI_AWIDTH-1:0]  i_addr,
  input  logic [31:0]            i_nbeats,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  input  logic                   i_s_valid,
  output logic                   o_s_ready,
  input  logic [AXI_DWIDTH-1:0]  i_s_data,
  input  logic                   m_axi_awready,
  output logic                   m_axi_awvalid,
  output logic [AXI_AWIDTH-1:0]  m_axi_awaddr,
  output logic [7:0]             m_axi_awlen,
  output logic [AXI_IDWIDTH-1:0] m_axi_awid,
  input  logic                   m_axi_wready,
  output logic                   m_axi_wvalid,
  output logic                   m_axi_wlast,
  output logic [AXI_DWIDTH-1:0]  m_axi_wdata,
  output logic                   m_axi_bready,
  input  logic                   m_axi_bvalid,
  input  logic [AXI_IDWIDTH-1:0] m_axi_bid,
  input  logic [1:0]             m_axi_bresp
);

  wr_state_e               state_q, state_d;
  logic [AXI_AWIDTH-1:0]   addr_q, addr_d;
  logic [AXI_AWIDTH-1:0]   awaddr_q, awaddr_d;
  logic [31:0]             rem_q, rem_d;
  logic [8:0]              burst_q, burst_d;
  logic [7:0]              awlen_q, awlen_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    done_q, done_d;

  logic [8:0]              w_burst;
  logic [8:0]              w_burst_m1;
  logic [31:0]             w_rem_next;
  logic                    w_resp_err;
  logic                    w_unused;

  axi_burst_len_calc #(
    .MAX_BURST (MAX_BURST)
  ) u_len_calc (
    .remaining_i   (rem_q),
    .beat_offset_i (addr_q[11:3]),
    .burst_o       (w_burst)
  );

  assign w_burst_m1 = w_burst - 9'd1;
  assign w_rem_next = rem_q - 32'(burst_q);
  assign w_resp_err = (m_axi_bresp != AXI_RESP_OKAY);
  assign w_unused   = ^{m_axi_bid, i_addr[2:0], w_burst_m1[8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      awaddr_q <= '0;
      rem_q    <= '0;
      burst_q  <= '0;
      awlen_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      awaddr_q <= awaddr_d;
      rem_q    <= rem_d;
      burst_q  <= burst_d;
      awlen_q  <= awlen_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    awaddr_d = awaddr_q;
    rem_d    = rem_q;
    burst_d  = burst_q;
    awlen_d  = awlen_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          err_d = 1'b0;
          if (i_nbeats != 32'd0) begin
            addr_d  = {i_addr[AXI_AWIDTH-1:3], 3'b000};
            rem_d   = i_nbeats;
            state_d = ST_CALC;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_CALC: begin
        burst_d  = w_burst;
        awaddr_d = addr_q;
        awlen_d  = w_burst_m1[7:0];
        cnt_d    = 8'd0;
        state_d  = ST_AW;
      end
      ST_AW: begin
        if (m_axi_awready) state_d = ST_W;
      end
      ST_W: begin
        if (i_s_valid && m_axi_wready) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == awlen_q) state_d = ST_B;
        end
      end
      ST_B: begin
        if (m_axi_bvalid) begin
          err_d  = err_q | w_resp_err;
          addr_d = addr_q + AXI_AWIDTH'({burst_q, 3'b000});
          rem_d  = w_rem_next;
          if (w_rem_next == 32'd0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
`ifdef AXI_MM_BURST_WRITER_ABORT_EN
          end else if (w_resp_err) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Data path is a pure pass-through while in W; outputs read zero elsewhere.
  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = done_q;
  assign o_err         = err_q;
  assign m_axi_awvalid = (state_q == ST_AW);
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awid    = AXI_IDWIDTH'(AXI_ID);
  assign m_axi_wvalid  = (state_q == ST_W) && i_s_valid;
  assign o_s_ready     = (state_q == ST_W) && m_axi_wready;
  assign m_axi_wdata   = (state_q == ST_W) ? i_s_data : '0;
  assign m_axi_wlast   = (state_q == ST_W) && (cnt_q == awlen_q);
  assign m_axi_bready  = (state_q == ST_B);

endmodule

`default_nettype wire

// File: tb/tb_axi_mm_burst_writer.sv
// ============================================================================
// Module : tb_axi_mm_burst_writer
// Directed bench with a simple AXI slave and stream source for the writer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_axi_mm_burst_writer;

  localparam int AW  = 64;
  localparam int IDW = 4;
  localparam int DW  = 64;

  logic           clk, rst;
  logic           i_start;
  logic [AW-1:0]  i_addr;
  logic [31:0]    i_nbeats;
  logic           o_busy, o_done, o_err;
  logic           i_s_valid, o_s_ready;
  logic [DW-1:0]  i_s_data;
  logic           m_axi_awready, m_axi_awvalid;
  logic [AW-1:0]  m_axi_awaddr;
  logic [7:0]     m_axi_awlen;
  logic [IDW-1:0] m_axi_awid;
  logic           m_axi_wready, m_axi_wvalid, m_axi_wlast;
  logic [DW-1:0]  m_axi_wdata;
  logic           m_axi_bready, m_axi_bvalid;
  logic [IDW-1:0] m_axi_bid;
  logic [1:0]     m_axi_bresp;

  axi_mm_burst_writer dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_addr        (i_addr),
    .i_nbeats      (i_nbeats),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err         (o_err),
    .i_s_valid     (i_s_valid),
    .o_s_ready     (o_s_ready),
    .i_s_data      (i_s_data),
    .m_axi_awready (m_axi_awready),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awlen   (m_axi_awlen),
    .m_axi_awid    (m_axi_awid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wlast   (m_axi_wlast),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_bready  (m_axi_bready),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bid     (m_axi_bid),
    .m_axi_bresp   (m_axi_bresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] aw_addr_log[$];
  logic [7:0]    aw_len_log[$];
  logic [DW-1:0] w_data_log[$];
  int            wlast_idx_log[$];
  int            w_beats, b_cnt, done_cnt, stab_err, sidx, aw_wait, aw_delay;
  bit            b_pending, stall_en, prev_aw_stall;
  logic [AW-1:0] prev_awaddr;
  logic [7:0]    prev_awlen;
  logic [1:0]    resp_tbl[0:7];

  function automatic logic [DW-1:0] stream_word(int i);
    return {32'hC0DE_0000 | 32'(i), ~32'(i)};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_model();
    aw_addr_log.delete(); aw_len_log.delete();
    w_data_log.delete();  wlast_idx_log.delete();
    w_beats = 0; b_cnt = 0; done_cnt = 0; stab_err = 0; sidx = 0;
    b_pending = 1'b0; prev_aw_stall = 1'b0;
    for (int i = 0; i < 8; i++) resp_tbl[i] = 2'b00;
  endtask

  // Slave + stream source: drive at negedge, observe the handshakes just before posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_axi_awvalid) begin
        m_axi_awready = (aw_wait >= aw_delay);
        aw_wait++;
      end else begin
        m_axi_awready = 1'b0;
        aw_wait = 0;
      end
      m_axi_wready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      i_s_valid    = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      i_s_data     = stream_word(sidx);
      m_axi_bvalid = b_pending;
      m_axi_bresp  = b_pending ? resp_tbl[b_cnt % 8] : 2'b00;
      #4;
      if (m_axi_awvalid) begin
        if (prev_aw_stall && (m_axi_awaddr !== prev_awaddr || m_axi_awlen !== prev_awlen))
          stab_err++;
        if (m_axi_awready) begin
          aw_addr_log.push_back(m_axi_awaddr);
          aw_len_log.push_back(m_axi_awlen);
          prev_aw_stall = 1'b0;
        end else begin
          prev_aw_stall = 1'b1;
          prev_awaddr   = m_axi_awaddr;
          prev_awlen    = m_axi_awlen;
        end
      end else begin
        prev_aw_stall = 1'b0;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_data_log.push_back(m_axi_wdata);
        if (m_axi_wlast) begin
          wlast_idx_log.push_back(w_beats);
          b_pending = 1'b1;
        end
        w_beats++;
        sidx++;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        b_pending = 1'b0;
        b_cnt++;
      end
      if (o_done) done_cnt++;
    end
  end

  task automatic do_start(input logic [AW-1:0] addr, input int n);
    tick();
    i_start = 1'b1; i_addr = addr; i_nbeats = 32'(n);
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (done_cnt == 0 && k < 3000) begin tick(); k++; end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s_timeout: done_cnt=%0d required>0", name, done_cnt);
    end
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (m_axi_awvalid !== 1'b0) begin errors++; $display("FAIL rst_awvalid: got %b want 0", m_axi_awvalid); end
    checks++; if (m_axi_wvalid !== 1'b0) begin errors++; $display("FAIL rst_wvalid: got %b want 0", m_axi_wvalid); end
    checks++; if (m_axi_bready !== 1'b0) begin errors++; $display("FAIL rst_bready: got %b want 0", m_axi_bready); end
    checks++; if (o_s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b want 0", o_s_ready); end
    checks++; if ({o_busy, o_done, o_err} !== 3'b000) begin errors++; $display("FAIL rst_status: got %b want 000", {o_busy, o_done, o_err}); end
    checks++; if (m_axi_awid !== 4'd0) begin errors++; $display("FAIL rst_awid: got %0d want 0", m_axi_awid); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_three_bursts();
    int bad;
    reset_model();
    do_start(64'h1000, 40);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL t1_busy: got %b want 1", o_busy); end
    wait_done("t1");
    checks++; if (aw_addr_log.size() != 3) begin errors++; $display("FAIL t1_nbursts: got %0d want 3", aw_addr_log.size()); end
    else begin
      checks++;
      if (aw_addr_log[0] !== 64'h1000 || aw_addr_log[1] !== 64'h1080 || aw_addr_log[2] !== 64'h1100) begin
        errors++; $display("FAIL t1_awaddr: got %h %h %h want 1000 1080 1100", aw_addr_log[0], aw_addr_log[1], aw_addr_log[2]);
      end
      checks++;
      if (aw_len_log[0] !== 8'd15 || aw_len_log[1] !== 8'd15 || aw_len_log[2] !== 8'd7) begin
        errors++; $display("FAIL t1_awlen: got %0d %0d %0d want 15 15 7", aw_len_log[0], aw_len_log[1], aw_len_log[2]);
      end
    end
    bad = 0;
    foreach (w_data_log[i]) if (w_data_log[i] !== stream_word(i)) bad++;
    checks++; if (w_data_log.size() != 40 || bad != 0) begin errors++; $display("FAIL t1_data: beats=%0d bad=%0d want 40 0", w_data_log.size(), bad); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL t1_done_pulses: got %0d want 1", done_cnt); end
    checks++; if (o_err !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL t1_end_status: err=%b busy=%b want 0 0", o_err, o_busy); end
  endtask

  task automatic test_4k_boundary();
    reset_model();
    do_start(64'h0FE0, 10);
    wait_done("t2");
    checks++;
    if (aw_addr_log.size() != 2) begin errors++; $display("FAIL t2_nbursts: got %0d want 2", aw_addr_log.size()); end
    else if (aw_addr_log[0] !== 64'h0FE0 || aw_len_log[0] !== 8'd3 || aw_addr_log[1] !== 64'h1000 || aw_len_log[1] !== 8'd5) begin
      errors++; $display("FAIL t2_bursts: got %h/%0d %h/%0d want 0fe0/3 1000/5", aw_addr_log[0], aw_len_log[0], aw_addr_log[1], aw_len_log[1]);
    end
    checks++; if (w_beats != 10) begin errors++; $display("FAIL t2_beats: got %0d want 10", w_beats); end
  endtask

  task automatic test_zero_beats();
    reset_model();
    do_start(64'h2000, 0);
    checks++; if (o_done !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL t3_done: done=%b busy=%b want 1 0", o_done, o_busy); end
    tick();
    checks++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL t3_after: done=%b busy=%b want 0 0", o_done, o_busy); end
    repeat (5) tick();
    checks++; if (aw_addr_log.size() != 0) begin errors++; $display("FAIL t3_no_aw: got %0d want 0", aw_addr_log.size()); end
  endtask

  task automatic test_stalls();
    int bad;
    reset_model();
    stall_en = 1'b1; aw_delay = 5;
    do_start(64'h3000, 17);
    wait_done("t4");
    stall_en = 1'b0; aw_delay = 0;
    checks++; if (stab_err != 0) begin errors++; $display("FAIL t4_aw_stable: got %0d changes want 0", stab_err); end
    checks++;
    if (aw_len_log.size() != 2) begin errors++; $display("FAIL t4_nbursts: got %0d want 2", aw_len_log.size()); end
    else if (aw_len_log[0] !== 8'd15 || aw_len_log[1] !== 8'd0 || aw_addr_log[1] !== 64'h3080) begin
      errors++; $display("FAIL t4_bursts: got len %0d %0d addr2 %h want 15 0 3080", aw_len_log[0], aw_len_log[1], aw_addr_log[1]);
    end
    checks++;
    if (wlast_idx_log.size() != 2) begin errors++; $display("FAIL t4_wlast_count: got %0d want 2", wlast_idx_log.size()); end
    else if (wlast_idx_log[0] != 15 || wlast_idx_log[1] != 16) begin
      errors++; $display("FAIL t4_wlast_pos: got %0d %0d want 15 16", wlast_idx_log[0], wlast_idx_log[1]);
    end
    bad = 0;
    foreach (w_data_log[i]) if (w_data_log[i] !== stream_word(i)) bad++;
    checks++; if (w_data_log.size() != 17 || bad != 0) begin errors++; $display("FAIL t4_data: beats=%0d bad=%0d want 17 0", w_data_log.size(), bad); end
  endtask

  task automatic test_bresp_error();
    reset_model();
    resp_tbl[0] = 2'b10;
    do_start(64'h6000, 32);
    wait_done("t5");
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL t5_err: got %b want 1", o_err); end
`ifdef AXI_MM_BURST_WRITER_ABORT_EN
    checks++; if (aw_addr_log.size() != 1 || w_beats != 16) begin errors++; $display("FAIL t5_abort: bursts=%0d beats=%0d want 1 16", aw_addr_log.size(), w_beats); end
`else
    checks++; if (aw_addr_log.size() != 2 || w_beats != 32) begin errors++; $display("FAIL t5_continue: bursts=%0d beats=%0d want 2 32", aw_addr_log.size(), w_beats); end
`endif
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL t5_done_pulses: got %0d want 1", done_cnt); end
    // A fresh start must clear the sticky error.
    reset_model();
    do_start(64'h7000, 2);
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL t5_err_clear: got %b want 0", o_err); end
    wait_done("t5b");
  endtask

  task automatic test_mid_reset();
    int k, beats_at_rst, aw_at_rst;
    reset_model();
    do_start(64'h1000, 40);
    k = 0;
    while (w_beats < 5 && k < 200) begin tick(); k++; end
    checks++; if (w_beats < 5) begin errors++; $display("FAIL t6_reach_w: beats=%0d want>=5", w_beats); end
    rst = 1'b1;
    tick();
    checks++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, o_s_ready, o_busy, o_done, o_err} !== 8'h00) begin
      errors++; $display("FAIL t6_rst_outputs: got %b want 00000000",
        {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, o_s_ready, o_busy, o_done, o_err});
    end
    checks++; if (m_axi_awaddr !== 64'd0 || m_axi_awlen !== 8'd0 || m_axi_wdata !== 64'd0) begin
      errors++; $display("FAIL t6_rst_regs: awaddr=%h awlen=%0d wdata=%h want 0 0 0", m_axi_awaddr, m_axi_awlen, m_axi_wdata);
    end
    rst = 1'b0;
    beats_at_rst = w_beats; aw_at_rst = aw_addr_log.size();
    repeat (6) tick();
    checks++; if (w_beats != beats_at_rst || aw_addr_log.size() != aw_at_rst) begin
      errors++; $display("FAIL t6_quiet: beats %0d->%0d aw %0d->%0d want unchanged", beats_at_rst, w_beats, aw_at_rst, aw_addr_log.size());
    end
    reset_model();
    do_start(64'h5000, 5);
    wait_done("t6");
    checks++;
    if (aw_addr_log.size() != 1 || w_beats != 5 || w_data_log[0] !== stream_word(0) || w_data_log[4] !== stream_word(4)) begin
      errors++; $display("FAIL t6_restart: bursts=%0d beats=%0d want 1 5", aw_addr_log.size(), w_beats);
    end
    else if (aw_addr_log[0] !== 64'h5000 || aw_len_log[0] !== 8'd4) begin
      errors++; $display("FAIL t6_restart_aw: got %h/%0d want 5000/4", aw_addr_log[0], aw_len_log[0]);
    end
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_addr = '0; i_nbeats = '0;
    i_s_valid = 1'b0; i_s_data = '0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    m_axi_bid = '0; m_axi_bresp = 2'b00;
    stall_en = 1'b0; aw_delay = 0; aw_wait = 0;
    reset_model();
    test_reset();
    test_three_bursts();
    test_4k_boundary();
    test_zero_beats();
    test_stalls();
    test_bresp_error();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
